tqvp_uart_tx: RTL

- TinyQV byte peripheral that consumes the harness register bus (address / data_in / data_write / data_out) and drives a UART transmit line on uo_out.
- Bytes written by the host over the SPI register path are queued in a small FIFO and serialised 8N1, LSB first, at a programmable baud divisor.
- Sits directly downstream of the SPI register slave, in the user-peripheral slot of the test harness.

---
 rtl/tqvp_uart_tx.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/tqvp_uart_tx.sv
// tqvp_uart_tx - TinyQV byte peripheral: register-bus driven UART transmitter.
//
// Bytes written to TXDATA are queued in a small FIFO and sent 8N1, LSB first.
// Each bit lasts DIV+1 clocks.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ui_in[0]              cts_n (active low clear-to-send); other bits unused
//   uo_out                {5'b0, fifo_empty, busy, tx}
//   address/data_in/data_write   host register write path
//   data_out              register read data, combinational from address
//
// Registers: 0 TXDATA (w: push, r: level), 1 STATUS, 2 DIV_LO, 3 DIV_HI,
//            4 CTRL {cts_use, parity_en, invert, enable}.
//
// Build option: define TQVP_UART_PARITY_EN to add CTRL bit2 (parity_en) and
// an even-parity bit between the data bits and the stop bit.
module tqvp_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic [7:0] data_in,
  input  logic       data_write,
  output logic [7:0] data_out
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TQVP_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Control / configuration registers
  logic [15:0] div;
  logic        enable;
  logic        invert;
  logic        cts_use;
  logic        overflow;
  logic        parity_rd;

  // FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_req;
  logic             push_ok;
  logic             pop;

  // Transmitter
  state_t      state;
  state_t      state_n;
  logic [15:0] timer;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        bit_done;
  logic        start_ok;
  logic        busy;
  logic        line;
  logic        tx;

  logic unused_in;
  assign unused_in = &{1'b0, ui_in[7:1]};

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign push_req   = data_write && (address == 4'h0);
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push_ok    = push_req && (!fifo_full || pop);

  assign bit_done = (timer == 16'd0);
  // cts_n only matters here, i.e. at the moment a frame would begin.
  assign start_ok = enable && !fifo_empty && (!cts_use || !ui_in[0]);

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= DEFAULT_DIV;
      enable   <= 1'b0;
      invert   <= 1'b0;
      cts_use  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end else if (data_write && address == 4'h1 && data_in[3]) begin
        overflow <= 1'b0;
      end
      if (data_write) begin
        case (address)
          4'h2: div[7:0]  <= data_in;
          4'h3: div[15:8] <= data_in;
          4'h4: begin
            enable  <= data_in[0];
            invert  <= data_in[1];
            cts_use <= data_in[3];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TQVP_UART_PARITY_EN
  logic parity_en;
  logic par_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_en <= 1'b0;
    end else if (data_write && address == 4'h4) begin
      parity_en <= data_in[2];
    end
  end

  // Parity is captured with the byte, before shifting destroys it.
  always_ff @(posedge clk) begin
    if (pop) begin
      par_bit <= ^fifo_mem[rd_ptr];
    end
  end

  assign parity_rd = parity_en;
`else
  assign parity_rd = 1'b0;
`endif

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start_ok) state_n = S_START;
      end
      S_START: begin
        if (bit_done) state_n = S_DATA;
      end
      S_DATA: begin
        if (bit_done && bit_cnt == 3'd7) begin
`ifdef TQVP_UART_PARITY_EN
          state_n = parity_en ? S_PARITY : S_STOP;
`else
          state_n = S_STOP;
`endif
        end
      end
`ifdef TQVP_UART_PARITY_EN
      S_PARITY: begin
        if (bit_done) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next frame when possible: no idle gap.
        if (bit_done) state_n = start_ok ? S_START : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state != S_IDLE);
    pop  = start_ok && ((state == S_IDLE) || (state == S_STOP && bit_done));
    line = 1'b1;
    case (state)
      S_START: line = 1'b0;
      S_DATA:  line = shift[0];
`ifdef TQVP_UART_PARITY_EN
      S_PARITY: line = par_bit;
`endif
      default: line = 1'b1;
    endcase
    tx = line ^ invert;
  end

  // ---------------- bit timer and data path ----------------
  // The timer reloads from the live DIV register, so a DIV write only takes
  // effect at the next bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= 16'd0;
      bit_cnt <= 3'd0;
    end else begin
      if (pop) begin
        timer   <= div;
        bit_cnt <= 3'd0;
      end else if (busy) begin
        timer <= bit_done ? div : timer - 16'd1;
        if (state == S_DATA && bit_done) begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= fifo_mem[rd_ptr];
    end else if (state == S_DATA && bit_done) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  // ---------------- outputs / read mux ----------------
  assign uo_out = {5'b0, fifo_empty, busy, tx};

  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0: data_out = 8'(level);
      4'h1: data_out = {4'b0, overflow, fifo_empty, fifo_full, busy};
      4'h2: data_out = div[7:0];
      4'h3: data_out = div[15:8];
      4'h4: data_out = {4'b0, cts_use, parity_rd, invert, enable};
      default: data_out = 8'h00;
    endcase
  end

endmodule
